// File: rtl/pb_mcast_unroller_pkg.sv
// Shared types and defaults for the multicast unroller.
// Default field geometry matches the cluster rule of the multicast SAM in picobello_pkg:
// Y tile field at [19:18], X tile field at [22:20], 48-bit addresses.
package pb_mcast_unroller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefAddrWidth      = 48;
  localparam int unsigned DefYOffset        = 18;
  localparam int unsigned DefYLen           = 2;
  localparam int unsigned DefXOffset        = 20;
  localparam int unsigned DefXLen           = 3;
  localparam int unsigned DefMaxOutstanding = 8;

  // Counter width able to hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_mcast_unroller_subset_iter.sv
// Subset iterator: walks every subset of a mask in ascending order, starting at zero.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        restart the walk at subset 0
//   advance_i     step to the next subset
//   mask_i        node-field mask being enumerated (must be held stable during a walk)
//   subset_o      current subset
//   last_o        current subset is the final one (subset == mask)
module pb_mcast_unroller_subset_iter
  import pb_mcast_unroller_pkg::*;
#(
  parameter int unsigned NodeBits = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                advance_i,
  input  logic [NodeBits-1:0] mask_i,
  output logic [NodeBits-1:0] subset_o,
  output logic                last_o
);

  logic [NodeBits-1:0] subset_q, subset_d, subset_next;

  // Filling the non-mask bits with ones makes the +1 carry ripple straight through them,
  // so the increment only ever lands on mask bits. Final carry is dropped.
  assign subset_next = ((subset_q | ~mask_i) + NodeBits'(1)) & mask_i;

  always_comb begin
    subset_d = subset_q;
    if (load_i) begin
      subset_d = '0;
    end else if (advance_i) begin
      subset_d = subset_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      subset_q <= '0;
    end else begin
      subset_q <= subset_d;
    end
  end

  assign subset_o = subset_q;
  assign last_o   = (subset_q == mask_i);

endmodule

// File: rtl/pb_mcast_unroller.sv
// Multicast unroller: expands one multicast request into one unicast per selected cluster tile,
// counts the unicast responses and returns a single merged completion.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      multicast request handshake (req_addr_i, req_mask_i)
//   out_valid_o/out_ready_i      unicast request handshake (out_addr_o, out_last_o)
//   rsp_valid_i, rsp_err_i       unicast response, always accepted
//   done_valid_o/done_ready_i    merged completion handshake (done_err_o)
//   busy_o                       sequence in progress
module pb_mcast_unroller
  import pb_mcast_unroller_pkg::*;
#(
  parameter int unsigned AddrWidth      = DefAddrWidth,
  parameter int unsigned YOffset        = DefYOffset,
  parameter int unsigned YLen           = DefYLen,
  parameter int unsigned XOffset        = DefXOffset,
  parameter int unsigned XLen           = DefXLen,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_mask_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic                 out_last_o,
  input  logic                 rsp_valid_i,
  input  logic                 rsp_err_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_err_o,
  output logic                 busy_o
);

  localparam int unsigned NodeBits = XLen + YLen;
  localparam int unsigned CntWidth = cnt_width(MaxOutstanding);

  // Node field is {X, Y}, so Y occupies the low bits of the packed value.
  function automatic logic [NodeBits-1:0] get_node(input logic [AddrWidth-1:0] a);
    return {a[XOffset +: XLen], a[YOffset +: YLen]};
  endfunction

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [NodeBits-1:0]  mask_q, base_q;
  logic [CntWidth-1:0]  outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 req_hs, issue_hs, rsp_take;
  logic [NodeBits-1:0]  subset, node;
  logic                 subset_last;

  // Mask bits outside the node field are deliberately ignored.
  logic unused_mask;
  assign unused_mask = ^req_mask_i;

  assign req_hs   = req_valid_i & req_ready_o;
  assign issue_hs = out_valid_o & out_ready_i;
  // Responses with nothing outstanding are dropped so the counter cannot underflow.
  assign rsp_take = rsp_valid_i & (outstanding_q != '0);

  pb_mcast_unroller_subset_iter #(
    .NodeBits(NodeBits)
  ) u_subset_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (req_hs),
    .advance_i(issue_hs),
    .mask_i   (mask_q),
    .subset_o (subset),
    .last_o   (subset_last)
  );

  assign node = base_q | subset;

  always_comb begin
    out_addr_o                    = addr_q;
    out_addr_o[YOffset +: YLen]   = node[YLen-1:0];
    out_addr_o[XOffset +: XLen]   = node[NodeBits-1:YLen];
  end

  // All handshake outputs derive from registered state only.
  assign req_ready_o  = (state_q == StIdle);
  assign out_valid_o  = (state_q == StIssue) && (outstanding_q < CntWidth'(MaxOutstanding));
  assign out_last_o   = out_valid_o & subset_last;
  assign done_valid_o = (state_q == StDone);
  assign done_err_o   = done_valid_o & err_q;
  assign busy_o       = (state_q != StIdle);

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_hs && !rsp_take) begin
      outstanding_d = outstanding_q + CntWidth'(1);
    end else if (!issue_hs && rsp_take) begin
      outstanding_d = outstanding_q - CntWidth'(1);
    end
  end

  always_comb begin
    err_d = err_q | (rsp_take & rsp_err_i);
    if (req_hs) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StIssue;
      StIssue: if (issue_hs && subset_last) state_d = StDrain;
      // Looking at the next count lets done follow the final response by one cycle.
      StDrain: if (outstanding_d == '0) state_d = StDone;
      StDone:  if (done_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      mask_q        <= '0;
      base_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      if (req_hs) begin
        addr_q <= req_addr_i;
        mask_q <= get_node(req_mask_i);
        base_q <= get_node(req_addr_i) & ~get_node(req_mask_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && rsp_valid_i) begin
      assert (outstanding_q != '0)
        else $error("response received with no unicast outstanding; ignored");
    end
  end

endmodule

// File: tb/tb_pb_mcast_unroller.sv
module tb_pb_mcast_unroller;

  localparam int unsigned AW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr, req_mask;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] out_addr;
  logic          rsp_valid, rsp_err;
  logic          done_valid, done_ready, done_err, busy;

  always #5 clk = ~clk;

  pb_mcast_unroller #(
    .AddrWidth     (48),
    .YOffset       (18),
    .YLen          (2),
    .XOffset       (20),
    .XLen          (3),
    .MaxOutstanding(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_mask_i  (req_mask),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .rsp_valid_i (rsp_valid),
    .rsp_err_i   (rsp_err),
    .done_valid_o(done_valid),
    .done_ready_i(done_ready),
    .done_err_o  (done_err),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst req_ready", req_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_err", done_err, 0);
    chk("rst busy", busy, 0);
  endtask

  typedef struct {
    logic [AW-1:0]      addr;
    logic [AW-1:0]      mask;
    int                 n;
    logic [3:0][AW-1:0] exp;
    int                 err_idx;
  } vec_t;

  vec_t vecs[5];

  // One full request: responses arrive one cycle after each unicast handshake.
  // With rand_ready the downstream stalls randomly and done is held off for 5 cycles.
  task automatic run_vec(input vec_t v, input bit rand_ready);
    int            got;
    int            t;
    bit            pend;
    int            pend_idx;
    bit            done;
    bit            stall;
    logic [AW-1:0] stall_addr;
    got = 0; t = 0; pend = 0; pend_idx = 0; done = 0; stall = 0; stall_addr = '0;
    @(negedge clk);
    chk("req_ready before request", req_ready, 1);
    req_valid = 1; req_addr = v.addr; req_mask = v.mask;
    @(negedge clk);
    req_valid = 0; req_addr = '0; req_mask = '0;
    t = 1;
    while (!done && t < 200) begin
      if (t == 1) chk("first valid latency", out_valid, 1);
      chk("req_ready while busy", req_ready, 0);
      if (stall) begin
        chk("stalled valid held", out_valid, 1);
        chk("stalled addr held", out_addr, stall_addr);
      end
      rsp_valid = pend;
      rsp_err   = pend && (pend_idx == v.err_idx);
      pend      = 0;
      if (done_valid) begin
        rsp_valid = 0; rsp_err = 0; out_ready = 0;
        chk("done_err", done_err, v.err_idx >= 0);
        chk("unicast count", got, v.n);
        if (!rand_ready) begin
          chk("done latency", t, v.n + 2);
          done_ready = 1;
        end else begin
          done_ready = 0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("done held", done_valid, 1);
            chk("req_ready during done", req_ready, 0);
          end
          done_ready = 1;
        end
        @(negedge clk);
        done_ready = 0;
        chk("done dropped", done_valid, 0);
        chk("req_ready after done", req_ready, 1);
        done = 1;
      end else begin
        out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        stall      = out_valid && !out_ready;
        stall_addr = out_addr;
        if (out_valid && out_ready) begin
          if (got < 4) chk("unicast addr", out_addr, v.exp[got]);
          chk("unicast last", out_last, got == v.n - 1);
          pend = 1; pend_idx = got; got++;
        end
        @(negedge clk);
        t++;
      end
    end
    if (!done) chk("done timeout", 0, 1);
    rsp_valid = 0; rsp_err = 0; out_ready = 0;
  endtask

  initial begin
    int iss;
    int resp;
    int c;

    vecs[0] = '{addr: 48'h0000_0004_0000, mask: 48'h0000_0030_0000, n: 4, exp: '0, err_idx: -1};
    vecs[0].exp[0] = 48'h04_0000; vecs[0].exp[1] = 48'h14_0000;
    vecs[0].exp[2] = 48'h24_0000; vecs[0].exp[3] = 48'h34_0000;
    vecs[1] = '{addr: 48'h0000_0024_0000, mask: 48'h0, n: 1, exp: '0, err_idx: -1};
    vecs[1].exp[0] = 48'h24_0000;
    vecs[2] = '{addr: 48'h0000_0004_0100, mask: 48'h0000_0000_0F00, n: 1, exp: '0, err_idx: -1};
    vecs[2].exp[0] = 48'h04_0100;
    // Masked address bit is cleared from the base; upper/lower bits pass through.
    vecs[3] = '{addr: 48'hA5A5_0004_0001, mask: 48'h0000_0004_0000, n: 2, exp: '0, err_idx: -1};
    vecs[3].exp[0] = 48'hA5A5_0000_0001; vecs[3].exp[1] = 48'hA5A5_0004_0001;
    vecs[4] = vecs[0];
    vecs[4].err_idx = 2;

    rst = 1; req_valid = 0; req_addr = '0; req_mask = '0;
    out_ready = 0; rsp_valid = 0; rsp_err = 0; done_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_reset_vals();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Backpressure on both the unicast and the completion side.
    run_vec(vecs[0], 1'b1);

    // Outstanding limit with all 32 tiles and withheld responses.
    @(negedge clk);
    req_valid = 1; req_addr = '0; req_mask = 48'h0000_01FC_0000;
    @(negedge clk);
    req_valid = 0; req_mask = '0; out_ready = 1;
    iss = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        chk("limit addr", out_addr, AW'(iss) << 18);
        iss++;
      end
      @(negedge clk);
    end
    chk("limit issued", iss, 8);
    chk("limit valid low", out_valid, 0);
    rsp_valid = 1; rsp_err = 1;
    @(negedge clk);
    rsp_valid = 0; rsp_err = 0;
    chk("resume valid", out_valid, 1);
    chk("resume addr", out_addr, AW'(iss) << 18);
    iss++;
    @(negedge clk);
    chk("relimit valid low", out_valid, 0);
    resp = 1;
    c = 0;
    while (!done_valid && c < 300) begin
      rsp_valid = (resp < iss);
      if (rsp_valid) resp++;
      if (out_valid) begin
        chk("wide addr", out_addr, AW'(iss) << 18);
        chk("wide last", out_last, iss == 31);
        iss++;
      end
      @(negedge clk);
      c++;
    end
    rsp_valid = 0; out_ready = 0;
    chk("wide done", done_valid, 1);
    chk("wide done_err", done_err, 1);
    chk("wide issued", iss, 32);
    done_ready = 1;
    @(negedge clk);
    done_ready = 0;

    // Reset after two of four unicasts, with stray responses during reset.
    req_valid = 1; req_addr = vecs[0].addr; req_mask = vecs[0].mask;
    @(negedge clk);
    req_valid = 0; req_mask = '0; out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      chk("pre-reset valid", out_valid, 1);
      @(negedge clk);
    end
    chk("pre-reset busy", busy, 1);
    rst = 1; out_ready = 0; rsp_valid = 1;
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    rst = 0; rsp_valid = 0;
    @(negedge clk);
    chk_reset_vals();
    run_vec(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
